asic_iobank: RTL and testbench

//  Parametrised NPINS-wide GPIO bank: the next generation of the soft pad buffer.

---
 rtl/asic_iobank.sv | 111 +++++++++++
 tb/tb_asic_iobank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/asic_iobank.sv
// asic_iobank: NPINS-wide GPIO bank between the core GPIO registers and the pad ring.
// Registered push-pull/open-drain drive, synchronised + debounced inputs, sticky edge IRQs.
module asic_iobank #(
  parameter int NPINS    = 8,
  parameter int SYNC     = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [NPINS-1:0] pad,
  input  logic [NPINS-1:0] dout,
  input  logic [NPINS-1:0] oen,
  input  logic [NPINS-1:0] od,
  input  logic [NPINS-1:0] ie,
  output logic [NPINS-1:0] din,
  input  logic [NPINS-1:0] rise_en,
  input  logic [NPINS-1:0] fall_en,
  input  logic [NPINS-1:0] irq_clr,
  output logic [NPINS-1:0] irq_status,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [NPINS-1:0]           dout_r;
  logic [NPINS-1:0]           oen_r;
  logic [NPINS-1:0]           od_r;
  logic [NPINS-1:0]           pad_z_s;
  logic [NPINS-1:0]           raw_s;
  logic [SYNC-1:0][NPINS-1:0] sync_r;
  logic [NPINS-1:0]           s_s;
  logic [NPINS-1:0][CW-1:0]   cnt_r;
  logic [NPINS-1:0]           stable_r;
  logic [NPINS-1:0]           stable_d_r;
  logic [NPINS-1:0]           rise_s;
  logic [NPINS-1:0]           fall_s;
  logic [NPINS-1:0]           set_s;
  logic [NPINS-1:0]           irq_status_r;

  // Output drive registers; reset leaves every pad released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_r <= '0;
      oen_r  <= '1;
      od_r   <= '0;
    end else begin
      dout_r <= dout;
      oen_r  <= oen;
      od_r   <= od;
    end
  end

  // Open-drain pins only ever pull low; a high level is left to the external pull.
  assign pad_z_s = oen_r | (od_r & dout_r);

  for (genvar g = 0; g < NPINS; g++) begin : g_pad
    assign pad[g] = pad_z_s[g] ? 1'bz : dout_r[g];
  end

  assign raw_s = pad & ie;
  assign s_s   = sync_r[SYNC-1];

  // Input synchroniser chain; stage 0 samples the gated pad level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC-2:0], raw_s};
    end
  end

  // Per-pin debounce: a new level is accepted after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      stable_r <= '0;
    end else begin
      for (int i = 0; i < NPINS; i++) begin
        if (s_s[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          stable_r[i] <= s_s[i];
          cnt_r[i]    <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign rise_s = stable_r & ~stable_d_r;
  assign fall_s = ~stable_r & stable_d_r;
  assign set_s  = (rise_s & rise_en) | (fall_s & fall_en);

  // Edge history and sticky interrupt flags; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d_r   <= '0;
      irq_status_r <= '0;
    end else begin
      stable_d_r   <= stable_r;
      irq_status_r <= set_s | (irq_status_r & ~irq_clr);
    end
  end

  assign din        = stable_r;
  assign irq_status = irq_status_r;
  assign irq        = |irq_status_r;

endmodule

// File: tb/tb_asic_iobank.sv
// Directed, self-checking bench for asic_iobank (NPINS=8, SYNC=2, DEBOUNCE=4).
// Pads carry a pull-up; released pins are told apart from driven ones by a second probe pulling low.
module tb_asic_iobank;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] oen;
    logic [N-1:0] od;
    logic [N-1:0] dout;
    logic [N-1:0] exp;
    logic [N-1:0] zm;
  } drv_vec_t;

  logic         clk = 1'b0;
  logic         reset;
  wire  [N-1:0] pad;
  logic [N-1:0] dout, oen, od, ie, rise_en, fall_en, irq_clr;
  logic [N-1:0] din, irq_status;
  logic         irq;
  logic [N-1:0] drv_en, drv_val;
  int           checks   = 0;
  int           failures = 0;
  drv_vec_t     vecs [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_tbpad
    assign pad[g] = drv_en[g] ? drv_val[g] : 1'bz;
    pullup pu (pad[g]);
  end

  asic_iobank #(.NPINS(N), .SYNC(2), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .pad(pad), .dout(dout), .oen(oen), .od(od),
    .ie(ie), .din(din), .rise_en(rise_en), .fall_en(fall_en),
    .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Released pins read 1 through the pull-up, and 0 when the bench pulls them low.
  task automatic chk_pad(input string nm, input logic [N-1:0] exp, input logic [N-1:0] zm);
    drv_en = 8'h00;
    #1;
    chk({nm, "_rel"}, 32'(pad), 32'(exp | zm));
    drv_val = 8'h00;
    drv_en  = zm;
    #1;
    chk({nm, "_pd"}, 32'(pad), 32'(exp & ~zm));
    drv_en = 8'h00;
    #1;
  endtask

  initial begin
    reset = 1'b1; dout = 8'h00; oen = 8'hFF; od = 8'h00; ie = 8'h00;
    rise_en = 8'h00; fall_en = 8'h00; irq_clr = 8'h00;
    drv_en = 8'h00; drv_val = 8'h00;

    //         oen     od      dout    exp     zm
    vecs[0] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{8'h0F, 8'h33, 8'h55, 8'h40, 8'h1F};
    vecs[5] = '{8'hA0, 8'h0C, 8'h3C, 8'h10, 8'hAC};

    // Reset state
    repeat (2) tick();
    chk("rst_din", 32'(din), 32'h0);
    chk("rst_irq_status", 32'(irq_status), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk_pad("rst_pad", 8'h00, 8'hFF);

    // Pins active (self-looped through ie), then asynchronous reset mid-cycle
    reset = 1'b0; oen = 8'h00; od = 8'h00; dout = 8'hFF; ie = 8'hFF; rise_en = 8'hFF;
    chk_pad("drv_latency", 8'h00, 8'hFF);
    repeat (10) tick();
    chk("active_din", 32'(din), 32'hFF);
    chk("active_irq", 32'(irq), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_din", 32'(din), 32'h0);
    chk("async_rst_irq_status", 32'(irq_status), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk_pad("async_rst_pad", 8'h00, 8'hFF);
    tick();
    reset = 1'b0; oen = 8'hFF; dout = 8'h00; ie = 8'h00; rise_en = 8'h00;

    // Output path vectors
    for (int k = 0; k < 6; k++) begin
      oen = vecs[k].oen; od = vecs[k].od; dout = vecs[k].dout;
      tick();
      chk_pad($sformatf("vec%0d", k), vecs[k].exp, vecs[k].zm);
    end
    oen = 8'hFF; od = 8'h00; dout = 8'h00;
    tick();

    // Debounce latency and glitch rejection
    ie = 8'hFF; drv_en = 8'hFF; drv_val = 8'h00;
    repeat (8) tick();
    chk("deb_idle", 32'(din), 32'h0);
    drv_val = 8'hFF;
    repeat (5) tick();
    chk("deb_edge5", 32'(din), 32'h0);
    tick();
    chk("deb_edge6", 32'(din), 32'hFF);
    drv_val = 8'h00;
    repeat (8) tick();
    chk("deb_fall", 32'(din), 32'h0);
    drv_val = 8'hFF;
    repeat (3) tick();
    drv_val = 8'h00;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("glitch3_c%0d", c), 32'(din), 32'h0);
    end
    chk("glitch3_cnt", 32'(dut.cnt_r), 32'h0);
    drv_val = 8'hFF;
    repeat (4) tick();
    drv_val = 8'h00;
    tick();
    chk("pulse4_edge5", 32'(din), 32'h0);
    tick();
    chk("pulse4_edge6", 32'(din), 32'hFF);
    repeat (8) tick();
    chk("pulse4_back", 32'(din), 32'h0);

    // Input disabled while pad toggles
    ie = 8'h00; rise_en = 8'hFF; fall_en = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      drv_val = ~drv_val;
      tick();
      chk($sformatf("ie0_din_c%0d", c), 32'(din), 32'h0);
    end
    chk("ie0_irq_status", 32'(irq_status), 32'h0);
    rise_en = 8'h00; fall_en = 8'h00;

    // Interrupts on pin 3
    ie = 8'hFF; drv_val = 8'h00;
    repeat (8) tick();
    rise_en = 8'h08; drv_val = 8'h08;
    repeat (6) tick();
    chk("irq_din_edge6", 32'(din), 32'h08);
    chk("irq_edge6", 32'(irq_status), 32'h0);
    tick();
    chk("irq_edge7", 32'(irq_status), 32'h08);
    chk("irq_out", 32'(irq), 32'h1);
    rise_en = 8'h00;
    tick();
    chk("irq_en_off_hold", 32'(irq_status), 32'h08);
    irq_clr = 8'h08;
    tick();
    irq_clr = 8'h00;
    chk("irq_clr", 32'(irq_status), 32'h0);
    chk("irq_clr_out", 32'(irq), 32'h0);
    fall_en = 8'h08; drv_val = 8'h00;
    repeat (6) tick();
    chk("fall_din", 32'(din), 32'h0);
    chk("fall_pre", 32'(irq_status), 32'h0);
    irq_clr = 8'h08;
    tick();
    irq_clr = 8'h00;
    chk("set_wins", 32'(irq_status), 32'h08);
    tick();
    chk("set_hold", 32'(irq_status), 32'h08);
    irq_clr = 8'h08;
    tick();
    irq_clr = 8'h00; fall_en = 8'h00;
    chk("final_clr", 32'(irq_status), 32'h0);

    // Reset in the middle of a debounce count
    drv_val = 8'hFF;
    repeat (8) tick();
    chk("mid_din_hi", 32'(din), 32'hFF);
    drv_val = 8'h00;
    repeat (4) tick();
    chk("mid_cnt2", 32'(dut.cnt_r), 32'(24'o22222222));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_din", 32'(din), 32'h0);
    chk("mid_rst_cnt", 32'(dut.cnt_r), 32'h0);
    drv_val = 8'hFF;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_edge5", 32'(din), 32'h0);
    tick();
    chk("post_rst_edge6", 32'(din), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
